// File: rtl/dmem_wb_arbiter_pkg.sv
// Shared types for the two-master data-memory Wishbone arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int NM_HOLD_DEF = 16;

endpackage

// File: rtl/dmem_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the data memory slave between the core
// load/store port (m0) and the DMA/debug loader port (m1), with a hold limit.
module dmem_wb_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NM_HOLD = NM_HOLD_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  gnt_o
);

  localparam int HOLD_W = $clog2(NM_HOLD + 1);

  arb_state_e        state;
  logic              last;
  logic [HOLD_W-1:0] hold_cnt;

  logic              own_cyc;
  logic              own_stb;
  logic              oth_cyc;
  logic              hold_max;
  logic              release_bus;
  arb_state_e        oth_state;

  // View of the bus from the current owner's side, so both grant states share one rule set.
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    oth_cyc   = 1'b0;
    oth_state = IDLE;
    case (state)
      GNT0: begin
        own_cyc   = m0_cyc_i;
        own_stb   = m0_stb_i;
        oth_cyc   = m1_cyc_i;
        oth_state = GNT1;
      end
      GNT1: begin
        own_cyc   = m1_cyc_i;
        own_stb   = m1_stb_i;
        oth_cyc   = m0_cyc_i;
        oth_state = GNT0;
      end
      default: ;
    endcase
  end

  assign hold_max    = (hold_cnt == HOLD_W'(NM_HOLD));
  // Preemption only between beats: the owner must have stb low this cycle.
  assign release_bus = !own_cyc || (hold_max && oth_cyc && !own_stb);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= GNT0;
          end else if (m1_cyc_i) begin
            state <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (release_bus) begin
            last     <= (state == GNT1);
            hold_cnt <= '0;
            state    <= oth_cyc ? oth_state : IDLE;
          end else if (!hold_max) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own ack/timing.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_dmem_wb_arbiter.sv
// Directed bench for dmem_wb_arbiter: a small memory slave, an owner-based
// reference model checked every cycle, and literal expectations per scenario.
module tb_dmem_wb_arbiter;

  localparam int NM_HOLD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_wdat;
  logic [3:0]  m0_sel;
  logic [31:0] m0_rdat;
  logic        m0_ack;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_wdat;
  logic [3:0]  m1_sel;
  logic [31:0] m1_rdat;
  logic        m1_ack;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;
  logic [31:0] s_rdat;
  logic        s_ack;
  logic [1:0]  gnt;
  logic        slv_en;

  int n_vec = 0;
  int n_bad = 0;

  dmem_wb_arbiter #(.NM_HOLD(NM_HOLD)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
    .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .gnt_o(gnt)
  );

  always #5 clk = ~clk;

  // Memory slave: same-cycle ack, read data one cycle after the ack.
  logic [31:0] mem [0:63];
  assign s_ack = s_cyc & s_stb & slv_en;

  always @(posedge clk) begin
    if (s_ack && s_we) begin
      for (int b = 0; b < 4; b++)
        if (s_sel[b]) mem[s_adr[7:2]][8*b +: 8] <= s_wdat[8*b +: 8];
    end
    if (s_ack && !s_we) s_rdat <= mem[s_adr[7:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner is -1 (nobody), 0 or 1.
  int owner = -1;
  int last_m = 1;
  int held = 0;
  bit model_on = 1'b0;

  always @(posedge clk) begin : model_upd
    int o, l, h;
    bit own_c, own_s, oth_c;
    o = owner; l = last_m; h = held;
    if (rst) begin
      o = -1; l = 1; h = 0;
    end else if (o < 0) begin
      if (m0_cyc && m1_cyc) o = 1 - l;
      else if (m0_cyc)      o = 0;
      else if (m1_cyc)      o = 1;
      h = 0;
    end else begin
      own_c = (o == 0) ? m0_cyc : m1_cyc;
      own_s = (o == 0) ? m0_stb : m1_stb;
      oth_c = (o == 0) ? m1_cyc : m0_cyc;
      if (!own_c) begin
        l = o; o = oth_c ? 1 - o : -1; h = 0;
      end else if (h == NM_HOLD && oth_c && !own_s) begin
        l = o; o = 1 - o; h = 0;
      end else if (h < NM_HOLD) begin
        h = h + 1;
      end
    end
    owner  <= o;
    last_m <= l;
    held   <= h;
    if (rst) model_on <= 1'b1;
  end

  always @(negedge clk) begin : compare
    logic [1:0]  e_gnt;
    logic        e_cyc, e_stb, e_we, e_a0, e_a1;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    if (model_on) begin
      e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      e_cyc = (owner == 0) ? m0_cyc  : (owner == 1) ? m1_cyc  : 1'b0;
      e_stb = (owner == 0) ? m0_stb  : (owner == 1) ? m1_stb  : 1'b0;
      e_we  = (owner == 0) ? m0_we   : (owner == 1) ? m1_we   : 1'b0;
      e_adr = (owner == 0) ? m0_adr  : (owner == 1) ? m1_adr  : 32'h0;
      e_dat = (owner == 0) ? m0_wdat : (owner == 1) ? m1_wdat : 32'h0;
      e_sel = (owner == 0) ? m0_sel  : (owner == 1) ? m1_sel  : 4'h0;
      e_a0  = (owner == 0) && s_ack;
      e_a1  = (owner == 1) && s_ack;
      check("model_gnt",  32'(gnt),   32'(e_gnt));
      check("model_cyc",  32'(s_cyc), 32'(e_cyc));
      check("model_stb",  32'(s_stb), 32'(e_stb));
      check("model_we",   32'(s_we),  32'(e_we));
      check("model_adr",  s_adr,      e_adr);
      check("model_wdat", s_wdat,     e_dat);
      check("model_sel",  32'(s_sel), 32'(e_sel));
      check("model_ack0", 32'(m0_ack), 32'(e_a0));
      check("model_ack1", 32'(m1_ack), 32'(e_a1));
      check("model_rd0",  m0_rdat,    s_rdat);
      check("model_rd1",  m1_rdat,    s_rdat);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_m0(input logic c, s, w, input logic [31:0] a, d, input logic [3:0] sl);
    m0_cyc = c; m0_stb = s; m0_we = w; m0_adr = a; m0_wdat = d; m0_sel = sl;
  endtask

  task automatic set_m1(input logic c, s, w, input logic [31:0] a, d, input logic [3:0] sl);
    m1_cyc = c; m1_stb = s; m1_we = w; m1_adr = a; m1_wdat = d; m1_sel = sl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int sw;
    rst = 1'b1;
    slv_en = 1'b1;
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    neg();
    check("reset_gnt",  32'(gnt),    32'h0);
    check("reset_cyc",  32'(s_cyc),  32'h0);
    check("reset_adr",  s_adr,       32'h0);
    check("reset_ack0", 32'(m0_ack), 32'h0);
    check("reset_ack1", 32'(m1_ack), 32'h0);

    // m0 single write then readback
    set_m0(1, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    step(); neg();
    check("wr_gnt",  32'(gnt),    32'h1);
    check("wr_adr",  s_adr,       32'h10);
    check("wr_ack0", 32'(m0_ack), 32'h1);
    step();
    set_m0(0, 0, 0, 0, 0, 0);
    step();
    set_m0(1, 1, 0, 32'h10, 32'h0, 4'hF);
    step(); step();
    set_m0(1, 0, 0, 32'h10, 32'h0, 4'hF);
    neg();
    check("rd_data", m0_rdat, 32'hDEADBEEF);
    step();
    set_m0(0, 0, 0, 0, 0, 0);
    step();

    // simultaneous requests after reset: m0 first, then handover with no gap
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_m0(1, 1, 1, 32'h20, 32'h11111111, 4'hF);
    set_m1(1, 1, 1, 32'h30, 32'h22222222, 4'hF);
    step(); neg();
    check("tie1_gnt",  32'(gnt),    32'h1);
    check("tie1_ack1", 32'(m1_ack), 32'h0);
    check("tie1_adr",  s_adr,       32'h20);
    step();
    set_m0(0, 0, 0, 0, 0, 0);
    step(); neg();
    check("hand_gnt", 32'(gnt), 32'h2);
    check("hand_adr", s_adr,    32'h30);
    step();
    set_m1(0, 0, 0, 0, 0, 0);
    step();
    set_m0(1, 1, 1, 32'h20, 32'h33333333, 4'hF);
    set_m1(1, 1, 1, 32'h30, 32'h44444444, 4'hF);
    step(); neg();
    check("tie2_gnt", 32'(gnt), 32'h1);
    set_m0(0, 0, 0, 0, 0, 0);
    step();
    set_m1(0, 0, 0, 0, 0, 0);
    step();

    // non-granted master strobing without cyc has no effect on the slave
    set_m0(1, 1, 1, 32'h24, 32'hA5A5A5A5, 4'h3);
    set_m1(0, 1, 1, 32'h34, 32'h5A5A5A5A, 4'hC);
    step(); neg();
    check("ng_adr",  s_adr,       32'h24);
    check("ng_sel",  32'(s_sel),  32'h3);
    check("ng_dat",  s_wdat,      32'hA5A5A5A5);
    check("ng_ack1", 32'(m1_ack), 32'h0);
    step();
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    step();

    // hold limit: m1 idles on the bus (stb=0) while m0 waits
    set_m1(1, 0, 0, 32'h40, 32'h0, 4'hF);
    step();
    set_m0(1, 1, 0, 32'h10, 32'h0, 4'hF);
    sw = -1;
    for (int k = 1; k <= 30; k++) begin
      step(); neg();
      if (gnt == 2'b01) begin
        sw = k;
        break;
      end
    end
    check("hold_switch_cycle", 32'(sw), 32'd17);
    step(); step(); step();
    set_m0(0, 0, 0, 0, 0, 0);
    step(); neg();
    check("hold_back_gnt", 32'(gnt), 32'h2);
    set_m1(0, 0, 0, 0, 0, 0);
    step();

    // m1 streaming beats is never preempted; dropping stb lets m0 in
    set_m1(1, 1, 1, 32'h40, 32'hCAFEF00D, 4'hF);
    step();
    set_m0(1, 1, 0, 32'h10, 32'h0, 4'hF);
    for (int i = 0; i < 25; i++) begin
      step(); neg();
      check("busy_no_preempt", 32'(gnt), 32'h2);
    end
    set_m1(1, 0, 0, 32'h40, 32'h0, 4'hF);
    step(); neg();
    check("busy_preempt", 32'(gnt), 32'h1);
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    step(); step();

    // reset during a stalled m1 beat
    slv_en = 1'b0;
    set_m1(1, 1, 0, 32'h40, 32'h0, 4'hF);
    step(); neg();
    check("rst_pre_gnt", 32'(gnt), 32'h2);
    rst = 1'b1;
    step();
    slv_en = 1'b1;
    neg();
    check("rst_mid_cyc",  32'(s_cyc),  32'h0);
    check("rst_mid_gnt",  32'(gnt),    32'h0);
    check("rst_mid_ack1", 32'(m1_ack), 32'h0);
    rst = 1'b0;
    set_m1(0, 0, 0, 0, 0, 0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
